// File: rtl/rvfi_retire_buffer_if.sv
// Retirement/drain bundle for rvfi_retire_buffer.
// master drives retirements and out_ready; slave is the buffer.
interface rvfi_retire_buffer_if #(
   parameter int NRET  = 2,
   parameter int DEPTH = 8,
   parameter int XLEN  = 32
);
   logic [NRET-1:0]      ret_valid;
   logic [NRET-1:0]      ret_trap;
   logic [NRET*XLEN-1:0] ret_insn;
   logic [NRET*XLEN-1:0] ret_pc_rdata;
   logic [NRET*XLEN-1:0] ret_pc_wdata;

   logic                 out_valid;
   logic                 out_ready;
   logic [XLEN-1:0]      out_insn;
   logic [XLEN-1:0]      out_pc_rdata;
   logic [XLEN-1:0]      out_pc_wdata;
   logic                 out_trap;
   logic [63:0]          out_order;

   logic [$clog2(DEPTH):0] level;
   logic                 overflow;
   logic                 pc_err;

   modport master (
      output ret_valid, ret_trap, ret_insn,
      output ret_pc_rdata, ret_pc_wdata,
      output out_ready,
      input  out_valid, out_insn, out_pc_rdata,
      input  out_pc_wdata, out_trap, out_order,
      input  level, overflow, pc_err
   );

   modport slave (
      input  ret_valid, ret_trap, ret_insn,
      input  ret_pc_rdata, ret_pc_wdata,
      input  out_ready,
      output out_valid, out_insn, out_pc_rdata,
      output out_pc_wdata, out_trap, out_order,
      output level, overflow, pc_err
   );
endinterface

// File: rtl/rvfi_retire_buffer.sv
// RVFI retirement buffer: order stamping, in-order FIFO, one-per-cycle drain.
// Optional PC continuity check enabled by RVFI_PC_CHECK_EN.
module rvfi_retire_buffer #(
   parameter int NRET  = 2,
   parameter int DEPTH = 8,
   parameter int XLEN  = 32
) (
   input logic                 Clk,
   input logic                 Reset_n,
   rvfi_retire_buffer_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   typedef struct packed {
      logic [XLEN-1:0] insn;
      logic [XLEN-1:0] pc_rdata;
      logic [XLEN-1:0] pc_wdata;
      logic            trap;
      logic [63:0]     order;
   } ent_t;

   ent_t          mem_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [LW-1:0] level_q, level_d;
   logic [63:0]   cnt_q, cnt_d;
   logic          ovf_q, ovf_d;

   logic [LW-1:0] n;
   logic [LW-1:0] free;
   logic [LW-1:0] offs [NRET];
   ent_t          ent [NRET];
   logic          accept;
   logic          drop;
   logic          pop;

   // offs[i] is the slot of channel i within the compacted group
   always_comb begin
      n = '0;
      for (int i = 0; i < NRET; i++) begin
         offs[i]         = n;
         n               = n + LW'(bus.ret_valid[i]);
         ent[i].insn     = bus.ret_insn[i*XLEN +: XLEN];
         ent[i].pc_rdata = bus.ret_pc_rdata[i*XLEN +: XLEN];
         ent[i].pc_wdata = bus.ret_pc_wdata[i*XLEN +: XLEN];
         ent[i].trap     = bus.ret_trap[i];
         ent[i].order    = cnt_q + 64'(offs[i]);
      end
      free    = LW'(DEPTH) - level_q;
      accept  = (n <= free);
      drop    = !accept;
      pop     = (level_q != '0) && bus.out_ready;
      level_d = level_q + (accept ? n : '0) - LW'(pop);
      wr_d    = accept ? wr_q + n[PW-1:0] : wr_q;
      rd_d    = rd_q + PW'(pop);
      cnt_d   = cnt_q + 64'(n);
      ovf_d   = ovf_q | drop;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         for (int j = 0; j < DEPTH; j++)
            mem_q[j] <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         for (int i = 0; i < NRET; i++)
            if (accept && bus.ret_valid[i])
               mem_q[wr_q + offs[i][PW-1:0]] <= ent[i];
      end
   end

   // Head slot is never written while occupied, so outputs hold under stall
   assign bus.out_valid    = (level_q != '0);
   assign bus.out_insn     = mem_q[rd_q].insn;
   assign bus.out_pc_rdata = mem_q[rd_q].pc_rdata;
   assign bus.out_pc_wdata = mem_q[rd_q].pc_wdata;
   assign bus.out_trap     = mem_q[rd_q].trap;
   assign bus.out_order    = mem_q[rd_q].order;
   assign bus.level        = level_q;
   assign bus.overflow     = ovf_q;

`ifdef RVFI_PC_CHECK_EN
   logic [XLEN-1:0] last_q, last_d;
   logic            have_q, have_d;
   logic            err_q, err_d;

   always_comb begin
      last_d = last_q;
      have_d = have_q;
      err_d  = err_q;
      if (drop) begin
         have_d = 1'b0;
      end else begin
         for (int i = 0; i < NRET; i++) begin
            if (bus.ret_valid[i]) begin
               if (!ent[i].trap && have_d &&
                   ent[i].pc_rdata != last_d)
                  err_d = 1'b1;
               last_d = ent[i].pc_wdata;
               have_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         last_q <= '0;
         have_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         last_q <= last_d;
         have_q <= have_d;
         err_q  <= err_d;
      end
   end

   assign bus.pc_err = err_q;
`else
   assign bus.pc_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_retire_buffer.sv
// Randomized + directed bench for rvfi_retire_buffer.
// Reference model: a queue of stamped entries updated per cycle.
module tb_rvfi_retire_buffer;
   localparam int NRET  = 2;
   localparam int DEPTH = 8;
   localparam int XLEN  = 32;

   typedef struct {
      logic [XLEN-1:0] insn;
      logic [XLEN-1:0] pcr;
      logic [XLEN-1:0] pcw;
      logic            trap;
      logic [63:0]     order;
   } m_ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   m_ent_t          q[$];
   logic [63:0]     m_cnt;
   logic            m_ovf;
   logic            m_err;
   logic            m_have;
   logic [XLEN-1:0] m_last;
   logic [31:0]     cur_pc;

   rvfi_retire_buffer_if #(.NRET(NRET), .DEPTH(DEPTH), .XLEN(XLEN)) bus ();

   rvfi_retire_buffer #(.NRET(NRET), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .Clk     (clk),
      .Reset_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_cnt  = '0;
      m_ovf  = 1'b0;
      m_err  = 1'b0;
      m_have = 1'b0;
      m_last = '0;
   endtask

   task automatic model(input logic [NRET-1:0] v, input logic [NRET-1:0] t,
                        input logic [NRET*XLEN-1:0] ins,
                        input logic [NRET*XLEN-1:0] pr,
                        input logic [NRET*XLEN-1:0] pw,
                        input logic rdy);
      int n;
      int k;
      bit do_pop;
      m_ent_t e;
      n = $countones(v);
      do_pop = (q.size() != 0) && rdy;
      if (n > DEPTH - q.size()) begin
         m_ovf  = 1'b1;
         m_have = 1'b0;
      end else begin
         k = 0;
         for (int c = 0; c < NRET; c++) begin
            if (v[c]) begin
               e.insn  = ins[c*XLEN +: XLEN];
               e.pcr   = pr[c*XLEN +: XLEN];
               e.pcw   = pw[c*XLEN +: XLEN];
               e.trap  = t[c];
               e.order = m_cnt + 64'(k);
`ifdef RVFI_PC_CHECK_EN
               if (!e.trap && m_have && e.pcr != m_last)
                  m_err = 1'b1;
               m_last = e.pcw;
               m_have = 1'b1;
`endif
               q.push_back(e);
               k++;
            end
         end
      end
      if (do_pop)
         void'(q.pop_front());
      m_cnt = m_cnt + 64'(n);
   endtask

   task automatic compare_all();
      check("valid", 64'(bus.out_valid), 64'(q.size() != 0));
      check("level", 64'(bus.level), 64'(q.size()));
      check("overflow", 64'(bus.overflow), 64'(m_ovf));
      check("pc_err", 64'(bus.pc_err), 64'(m_err));
      if (q.size() != 0) begin
         check("order", bus.out_order, q[0].order);
         check("insn", 64'(bus.out_insn), 64'(q[0].insn));
         check("pc_rdata", 64'(bus.out_pc_rdata), 64'(q[0].pcr));
         check("pc_wdata", 64'(bus.out_pc_wdata), 64'(q[0].pcw));
         check("trap", 64'(bus.out_trap), 64'(q[0].trap));
      end
   endtask

   task automatic step(input logic [NRET-1:0] v, input logic [NRET-1:0] t,
                       input logic [NRET*XLEN-1:0] ins,
                       input logic [NRET*XLEN-1:0] pr,
                       input logic [NRET*XLEN-1:0] pw,
                       input logic rdy);
      bus.ret_valid    = v;
      bus.ret_trap     = t;
      bus.ret_insn     = ins;
      bus.ret_pc_rdata = pr;
      bus.ret_pc_wdata = pw;
      bus.out_ready    = rdy;
      model(v, t, ins, pr, pw, rdy);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   // Sequential-PC single/dual push helper
   task automatic push_seq(input logic [NRET-1:0] v, input logic rdy);
      logic [NRET*XLEN-1:0] pr;
      logic [NRET*XLEN-1:0] pw;
      logic [NRET*XLEN-1:0] ins;
      for (int c = 0; c < NRET; c++) begin
         pr[c*XLEN +: XLEN]  = cur_pc;
         pw[c*XLEN +: XLEN]  = cur_pc + 32'd4;
         ins[c*XLEN +: XLEN] = $urandom;
         if (v[c]) cur_pc = cur_pc + 32'd4;
      end
      step(v, '0, ins, pr, pw, rdy);
   endtask

   task automatic do_reset();
      bus.ret_valid = '0;
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_valid", 64'(bus.out_valid), 64'd0);
      check("rst_level", 64'(bus.level), 64'd0);
      check("rst_ovf", 64'(bus.overflow), 64'd0);
      check("rst_order", bus.out_order, 64'd0);
      check("rst_insn", 64'(bus.out_insn), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cur_pc = '0;
   endtask

   initial begin
      logic [NRET-1:0]      v;
      logic [NRET-1:0]      t;
      logic [NRET*XLEN-1:0] ins;
      logic [NRET*XLEN-1:0] pr;
      logic [NRET*XLEN-1:0] pw;
      bus.ret_valid    = '0;
      bus.ret_trap     = '0;
      bus.ret_insn     = '0;
      bus.ret_pc_rdata = '0;
      bus.ret_pc_wdata = '0;
      bus.out_ready    = 1'b0;
      cur_pc = '0;
      do_reset();

      // single-channel stream
      for (int i = 0; i < 3; i++) begin
         push_seq(2'b01, 1'b1);
         check("s_level", 64'(bus.level), 64'd1);
         check("s_order", bus.out_order, 64'(i));
      end
      push_seq(2'b00, 1'b1);

      // dual retire then sparse channel 1
      do_reset();
      step(2'b11, 2'b00, {32'hB, 32'hA}, {32'h14, 32'h10},
           {32'h18, 32'h14}, 1'b0);
      check("d_pc0", 64'(bus.out_pc_rdata), 64'h10);
      step(2'b10, 2'b00, {32'hC, 32'h0}, {32'h18, 32'h0},
           {32'h1C, 32'h0}, 1'b1);
      check("d_pc1", 64'(bus.out_pc_rdata), 64'h14);
      check("d_ord1", bus.out_order, 64'd1);
      push_seq(2'b00, 1'b1);
      check("d_pc2", 64'(bus.out_pc_rdata), 64'h18);
      check("d_ord2", bus.out_order, 64'd2);
      push_seq(2'b00, 1'b1);

      // overflow: fill, drop one group, drain, check gap
      do_reset();
      for (int i = 0; i < 4; i++) push_seq(2'b11, 1'b0);
      check("o_full", 64'(bus.level), 64'd8);
      push_seq(2'b11, 1'b0);
      check("o_flag", 64'(bus.overflow), 64'd1);
      for (int i = 0; i < 8; i++) push_seq(2'b00, 1'b1);
      push_seq(2'b01, 1'b1);
      check("o_gap", bus.out_order, 64'd10);
      push_seq(2'b00, 1'b1);

      // async reset with 5 queued and overflow set
      for (int i = 0; i < 5; i++) push_seq(2'b01, 1'b0);
      check("r_lvl5", 64'(bus.level), 64'd5);
      #2;
      rst_n = 1'b0;
      #1;
      check("r_valid", 64'(bus.out_valid), 64'd0);
      check("r_level", 64'(bus.level), 64'd0);
      check("r_ovf", 64'(bus.overflow), 64'd0);
      do_reset();
      push_seq(2'b01, 1'b0);
      check("r_first", bus.out_order, 64'd0);

`ifdef RVFI_PC_CHECK_EN
      do_reset();
      step(2'b01, 2'b00, '0, {32'h0, 32'h100}, {32'h0, 32'h104}, 1'b1);
      step(2'b01, 2'b00, '0, {32'h0, 32'h108}, {32'h0, 32'h10C}, 1'b1);
      check("pc_bad", 64'(bus.pc_err), 64'd1);
      do_reset();
      step(2'b01, 2'b01, '0, {32'h0, 32'h100}, {32'h0, 32'h108}, 1'b1);
      step(2'b01, 2'b00, '0, {32'h0, 32'h108}, {32'h0, 32'h10C}, 1'b1);
      check("pc_trap", 64'(bus.pc_err), 64'd0);
`endif

      // randomized traffic with backpressure and PC jumps
      do_reset();
      for (int i = 0; i < 600; i++) begin
         v = NRET'($urandom);
         t = '0;
         for (int c = 0; c < NRET; c++) begin
            t[c] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0)
               cur_pc = $urandom & 32'hFFFF_FFFC;
            pr[c*XLEN +: XLEN]  = cur_pc;
            pw[c*XLEN +: XLEN]  = cur_pc + 32'd4;
            ins[c*XLEN +: XLEN] = $urandom;
            if (v[c]) cur_pc = cur_pc + 32'd4;
         end
         step(v, t, ins, pr, pw,
              (i % 100 < 50) ? ($urandom_range(0, 3) != 0)
                             : ($urandom_range(0, 1) != 0));
         if (i == 300) do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
